// File: rtl/convclk_rdarb.sv
// Round-robin burst read arbiter over NCH read-side FIFOs with per-channel flush and a 2-entry output buffer.
// Data appears on odat 2 cycles after fiford; reads throttle on ordy. Build with CONVCLK_RDARB_WMARK_EN to gate eligibility on fill level.
module convclk_rdarb #(
  parameter int NCH   = 4,
  parameter int ADDRB = 4,
  parameter int DW    = 32,
  parameter int BURST = 4,
  parameter int WMARK = 2
) (
  input  logic                      rdclk,
  input  logic                      rdrst,
  input  logic [NCH-1:0]            fifonemp,
  input  logic [NCH*(ADDRB+1)-1:0]  rdfifolen,
  input  logic [NCH*DW-1:0]         rddat,
  input  logic [NCH-1:0]            flushreq,
  output logic [NCH-1:0]            fiford,
  output logic [NCH-1:0]            fifoflush,
  output logic [DW-1:0]             odat,
  output logic [$clog2(NCH)-1:0]    ochid,
  output logic                      ovld,
  input  logic                      ordy,
  output logic                      busy
);

  localparam int CW = $clog2(NCH);
  localparam int LW = ADDRB + 1;
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_FLUSH} state_t;

  state_t          state, nstate;
  logic [CW-1:0]   ptr, gnt, fch, rr_sel, pend_sel;
  logic [BW-1:0]   bcnt;
  logic [NCH-1:0]  pend, elig;
  logic            rr_hit, ld_gnt, ld_fch, exit_burst, rd_room;
  logic            rd_q;
  logic [CW-1:0]   rd_ch_q;
  logic [DW-1:0]   ob_dat [2];
  logic [CW-1:0]   ob_ch [2];
  logic            ob_wp, ob_rp, push, pop;
  logic [1:0]      ob_cnt;

`ifdef CONVCLK_RDARB_WMARK_EN
  always_comb begin
    for (int i = 0; i < NCH; i++)
      elig[i] = fifonemp[i] & ~pend[i] & (rdfifolen[i*LW +: LW] >= LW'(WMARK));
  end
`else
  logic unused_len;
  assign unused_len = ^rdfifolen;
  always_comb elig = fifonemp & ~pend;
`endif

  // Descending scans so the smallest offset / lowest index wins.
  always_comb begin
    int idx;
    idx      = 0;
    rr_hit   = 1'b0;
    rr_sel   = '0;
    pend_sel = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NCH;
      if (elig[idx]) begin
        rr_hit = 1'b1;
        rr_sel = CW'(idx);
      end
      if (pend[i]) pend_sel = CW'(i);
    end
  end

  // In-flight read counts against buffer space so a full buffer can never overflow.
  assign rd_room = (3'(ob_cnt) + 3'(rd_q)) < 3'd2;

  always_comb begin
    nstate     = state;
    fiford     = '0;
    fifoflush  = '0;
    ld_gnt     = 1'b0;
    ld_fch     = 1'b0;
    exit_burst = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pend) begin
          ld_fch = 1'b1;
          nstate = ST_FLUSH;
        end else if (rr_hit) begin
          ld_gnt = 1'b1;
          nstate = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!fifonemp[gnt]) begin
          exit_burst = 1'b1;
        end else if (rd_room) begin
          fiford[gnt] = 1'b1;
          if (bcnt == BW'(BURST-1)) exit_burst = 1'b1;
        end
        if (exit_burst) nstate = ST_IDLE;
      end
      ST_FLUSH: begin
        fifoflush[fch] = 1'b1;
        nstate         = ST_IDLE;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  assign push = rd_q;
  assign pop  = ovld & ordy;

  always_ff @(posedge rdclk) begin
    if (rdrst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      gnt     <= '0;
      fch     <= '0;
      bcnt    <= '0;
      pend    <= '0;
      rd_q    <= 1'b0;
      rd_ch_q <= '0;
      ob_wp   <= 1'b0;
      ob_rp   <= 1'b0;
      ob_cnt  <= '0;
      for (int i = 0; i < 2; i++) begin
        ob_dat[i] <= '0;
        ob_ch[i]  <= '0;
      end
    end else begin
      state <= nstate;
      // A request landing on the clear cycle re-arms the flag.
      pend  <= (pend & ~fifoflush) | flushreq;
      if (ld_gnt) begin
        gnt  <= rr_sel;
        bcnt <= '0;
      end else if (|fiford) begin
        bcnt <= bcnt + 1'b1;
      end
      if (exit_burst) ptr <= (gnt == CW'(NCH-1)) ? '0 : gnt + 1'b1;
      if (ld_fch) fch <= pend_sel;
      rd_q    <= |fiford;
      rd_ch_q <= gnt;
      if (push) begin
        ob_dat[ob_wp] <= rddat[rd_ch_q*DW +: DW];
        ob_ch[ob_wp]  <= rd_ch_q;
        ob_wp         <= ~ob_wp;
      end
      if (pop) ob_rp <= ~ob_rp;
      case ({push, pop})
        2'b10:   ob_cnt <= ob_cnt + 1'b1;
        2'b01:   ob_cnt <= ob_cnt - 1'b1;
        default: ob_cnt <= ob_cnt;
      endcase
    end
  end

  assign ovld  = (ob_cnt != 2'd0);
  assign odat  = ob_dat[ob_rp];
  assign ochid = ob_ch[ob_rp];
  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_convclk_rdarb.sv
// Directed bench for convclk_rdarb: behavioural read-side FIFOs feed the arbiter, outputs are collected at negedge.
// Inputs change 1 time unit after rdclk rises; DUT strobes are sampled on the falling edge.
module tb_convclk_rdarb;

  localparam int NCH = 4;
  localparam int LW  = 5;
  localparam int DW  = 32;

  logic              rdclk, rdrst, ovld, ordy, busy;
  logic [NCH-1:0]    fifonemp, flushreq, fiford, fifoflush;
  logic [NCH*LW-1:0] rdfifolen;
  logic [NCH*DW-1:0] rddat;
  logic [DW-1:0]     odat;
  logic [1:0]        ochid;

  convclk_rdarb #(.NCH(NCH), .ADDRB(4), .DW(DW), .BURST(4), .WMARK(2)) dut (
    .rdclk(rdclk), .rdrst(rdrst), .fifonemp(fifonemp), .rdfifolen(rdfifolen),
    .rddat(rddat), .flushreq(flushreq), .fiford(fiford), .fifoflush(fifoflush),
    .odat(odat), .ochid(ochid), .ovld(ovld), .ordy(ordy), .busy(busy)
  );

  initial rdclk = 1'b0;
  always #5 rdclk = ~rdclk;

  int             ncmp = 0;
  int             nerr = 0;
  int             fcnt [NCH];
  int             ridx [NCH];
  logic [NCH-1:0] rd_s, fl_s;
  logic [DW-1:0]  got_d [$];
  int             got_c [$];

  function automatic logic [DW-1:0] word(input int i, input int k);
    return {16'hC0DE, 8'(i), 8'(k)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh(input int i);
    fifonemp[i]          = (fcnt[i] > 0);
    rdfifolen[i*LW +: LW] = LW'(fcnt[i]);
  endtask

  task automatic load(input int i, input int n);
    fcnt[i] = n;
    ridx[i] = 0;
    refresh(i);
  endtask

  // One clock: sample strobes and output handshake, then advance the FIFO model.
  task automatic tick();
    @(negedge rdclk);
    rd_s = fiford;
    fl_s = fifoflush;
    if (ovld === 1'b1 && ordy === 1'b1) begin
      got_d.push_back(odat);
      got_c.push_back(int'(ochid));
    end
    @(posedge rdclk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (rd_s[i] === 1'b1) begin
        rddat[i*DW +: DW] = word(i, ridx[i]);
        ridx[i]++;
        if (fcnt[i] > 0) fcnt[i]--;
      end
      if (fl_s[i] === 1'b1) fcnt[i] = 0;
      refresh(i);
    end
  endtask

  task automatic wait_got(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && got_d.size() < n; k++) tick();
    chk(tag, 64'(got_d.size()), 64'(n));
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 100 && (busy || ovld); k++) tick();
    chk(tag, 64'({busy, ovld}), 64'd0);
  endtask

  task automatic clear_got();
    got_d.delete();
    got_c.delete();
  endtask

  initial begin
    int n, exp_ch;
    logic [NCH-1:0] exp_g;
    rdrst = 1'b1; ordy = 1'b1; flushreq = '0; rddat = '0; fifonemp = '0; rdfifolen = '0;
    for (int i = 0; i < NCH; i++) begin
      fcnt[i] = 0;
      ridx[i] = 0;
    end

    tick(); tick();
    chk("rst_fiford", 64'(fiford), 64'd0);
    chk("rst_flush",  64'(fifoflush), 64'd0);
    chk("rst_ovld",   64'(ovld), 64'd0);
    chk("rst_odat",   64'(odat), 64'd0);
    chk("rst_ochid",  64'(ochid), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    rdrst = 1'b0;

    // Four channels of 6 words: bursts of 4 then 2, round-robin from channel 0.
    clear_got();
    for (int i = 0; i < NCH; i++) load(i, 6);
    wait_got(24, 300, "A_count");
    n = 0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++)
        for (int k = (r == 0 ? 0 : 4); k < (r == 0 ? 4 : 6); k++) begin
          chk($sformatf("A_out%0d", n), 64'({8'(got_c[n]), got_d[n]}), 64'({8'(c), word(c, k)}));
          n++;
        end
    drain("A_drain");

    // Channel 2 alone with 3 words ends on empty; busy drops one cycle later.
    clear_got();
    load(2, 3);
    n = 0;
    for (int k = 0; k < 40 && n < 3; k++) begin
      tick();
      if (rd_s[2]) n++;
    end
    chk("B_reads", 64'(n), 64'd3);
    chk("B_busy_hold", 64'(busy), 64'd1);
    tick();
    chk("B_busy_low", 64'(busy), 64'd0);
    drain("B_drain");
    // Pointer now 3: with channels 1 and 3 loaded together, 3 goes first.
    clear_got();
    load(1, 1);
    load(3, 1);
    wait_got(2, 40, "B_ptr_count");
    chk("B_ptr_first",  64'(got_c[0]), 64'd3);
    chk("B_ptr_second", 64'(got_c[1]), 64'd1);
    drain("B_drain2");

    // Consumer stalls: only two reads may be outstanding, output held steady.
    clear_got();
    ordy = 1'b0;
    load(0, 4);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (rd_s[0]) n++;
      if (k == 7) chk("C_odat_t8", 64'(odat), 64'(word(0, 0)));
    end
    chk("C_reads",  64'(n), 64'd2);
    chk("C_ovld",   64'(ovld), 64'd1);
    chk("C_odat",   64'(odat), 64'(word(0, 0)));
    chk("C_ochid",  64'(ochid), 64'd0);
    ordy = 1'b1;
    wait_got(4, 60, "C_count");
    for (int k = 0; k < 4; k++)
      chk($sformatf("C_out%0d", k), 64'(got_d[k]), 64'(word(0, k)));
    drain("C_drain");

    // Flush request mid-burst on the granted channel waits for the burst to finish.
    clear_got();
    load(1, 4);
    n = 0;
    for (int k = 0; k < 20 && n == 0; k++) begin
      tick();
      if (rd_s[1]) n++;
    end
    flushreq = 4'b0010;
    tick();
    flushreq = '0;
    if (rd_s[1]) n++;
    for (int k = 0; k < 40 && fl_s == '0; k++) begin
      tick();
      if (rd_s[1]) n++;
    end
    chk("D_flush",      64'(fl_s), 64'b0010);
    chk("D_no_read",    64'(rd_s), 64'd0);
    chk("D_reads",      64'(n), 64'd4);
    tick();
    chk("D_flush_once", 64'(fl_s), 64'd0);
    wait_got(4, 40, "D_count");
    drain("D_drain");

    // Fill-level gating: channel 0 holds 1 word, channel 1 holds 3.
`ifdef CONVCLK_RDARB_WMARK_EN
    exp_g = 4'b0010;
`else
    exp_g = 4'b0001;
`endif
    clear_got();
    load(0, 1);
    load(1, 3);
    for (int k = 0; k < 20 && rd_s == '0; k++) tick();
    chk("E_grant", 64'(rd_s), 64'(exp_g));
    repeat (30) tick();
    load(0, 0);
    load(1, 0);
    drain("E_drain");

    // Reset one cycle after a read: the in-flight word must vanish.
    clear_got();
    load(3, 4);
    for (int k = 0; k < 20 && rd_s == '0; k++) tick();
    exp_ch = (rd_s == 4'b1000) ? 3 : 0;
    chk("F_read_ch", 64'(exp_ch), 64'd3);
    rdrst = 1'b1;
    tick();
    chk("F_ovld",   64'(ovld), 64'd0);
    chk("F_busy",   64'(busy), 64'd0);
    chk("F_fiford", 64'(fiford), 64'd0);
    chk("F_odat",   64'(odat), 64'd0);
    chk("F_ochid",  64'(ochid), 64'd0);
    chk("F_flush",  64'(fifoflush), 64'd0);
    load(3, 0);
    tick();
    rdrst = 1'b0;
    tick();
    chk("F_ovld_after", 64'(ovld), 64'd0);
    chk("F_nothing_out", 64'(got_d.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
